zone_stat_writer: RTL

- Per-zone luminance statistics engine and writer side of the zone RAM write bus (WEA / 8-bit data / 9-bit address).
- Consumes the active pixel stream on the panel clock and reduces each rectangular backlight zone to one 8-bit value (maximum luma by default).
- Writes one RAM word per zone as each band of zone rows completes.
- Downstream consumers of the bus (zone RAM, test-point snoop registers) see exactly one write per zone per frame.

---
 rtl/zone_stat_writer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/zone_stat_writer.sv
// zone_stat_writer
// Reduces the active pixel stream to one 8-bit statistic per backlight zone.
// It then writes each band of zones to the zone RAM bus, one word per clock.
//
// Configuration macro ZONE_STAT_AVG_EN:
//   undefined - the zone value is the maximum luma (8-bit accumulators).
//   defined   - the zone value is the mean luma. ZW and ZH must be powers of two.

module zone_stat_writer #(
  parameter int H_ACT   = 1024,
  parameter int V_ACT   = 768,
  parameter int ZONES_X = 16,
  parameter int ZONES_Y = 12
) (
  input  logic       iODCK,
  input  logic       iRST,
  input  logic       iVS,
  input  logic       iDE,
  input  logic [7:0] iY,
  output logic       oWEA,
  output logic [7:0] oData,
  output logic [8:0] oAddress,
  output logic       oBusy,
  output logic       oFrameDone
);

  localparam int ZW     = H_ACT / ZONES_X;
  localparam int ZH     = V_ACT / ZONES_Y;
  localparam int PX_W   = (ZW > 1)      ? $clog2(ZW)      : 1;
  localparam int COL_W  = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
  localparam int LINE_W = (ZH > 1)      ? $clog2(ZH)      : 1;
  localparam int BAND_W = (ZONES_Y > 1) ? $clog2(ZONES_Y) : 1;
  localparam int KW     = COL_W;
`ifdef ZONE_STAT_AVG_EN
  localparam int SHIFT  = $clog2(ZW * ZH);
`else
  localparam int SHIFT  = 0;
`endif
  localparam int ACC_W  = 8 + SHIFT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FLUSH
  } state_t;

  // Control and output registers
  state_t              state_q;
  logic [PX_W-1:0]     px_q;
  logic [COL_W-1:0]    col_q;
  logic [LINE_W-1:0]   line_q;
  logic [BAND_W-1:0]   band_q;
  logic                seq_run_q;
  logic [KW-1:0]       seq_k_q;
  logic                wea_q;
  logic [7:0]          data_q;
  logic [8:0]          addr_q;
  logic                busy_q;
  logic                done_q;

  // Statistics storage
  logic [ACC_W-1:0]    acc_q    [ZONES_X];
  logic [7:0]          shadow_q [ZONES_X];

  // Next-state helpers
  logic [ACC_W-1:0]    acc_d;
  logic [7:0]          shadow_d [ZONES_X];
  logic [8:0]          base_d;

  logic pix_ok;
  logic px_last;
  logic col_last;
  logic line_last;
  logic band_last;
  logic zone_first;
  logic band_end;
  logic frame_end;

  // The zone value is the top 8 bits of the accumulator.
  // That is the max directly, or the sum divided by the pixel count.
  function automatic logic [7:0] zone_val(input logic [ACC_W-1:0] a);
    return a[ACC_W-1 -: 8];
  endfunction

  // A pixel counts only while a frame is active. The frame-start cycle is not a pixel.
  assign pix_ok     = (state_q == S_ACTIVE) && iDE && !iVS;
  assign px_last    = (px_q   == PX_W'(ZW - 1));
  assign col_last   = (col_q  == COL_W'(ZONES_X - 1));
  assign line_last  = (line_q == LINE_W'(ZH - 1));
  assign band_last  = (band_q == BAND_W'(ZONES_Y - 1));
  assign zone_first = (line_q == '0) && (px_q == '0);
  assign band_end   = pix_ok && px_last && col_last && line_last;
  assign frame_end  = band_end && band_last;
  assign base_d     = 9'(band_q) * 9'(ZONES_X);

  // Accumulator entry for the current column, updated with the incoming pixel
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    acc_d = acc_q[col_q];
    if (zone_first) begin
      acc_d = ACC_W'(iY);
    end else begin
`ifdef ZONE_STAT_AVG_EN
      acc_d = acc_q[col_q] + ACC_W'(iY);
`else
      if (iY > acc_q[col_q]) acc_d = ACC_W'(iY);
`endif
    end
  end

  // Snapshot of the finished band; the last column includes the band-end pixel
  always_comb begin
    for (int k = 0; k < ZONES_X; k++) begin
      shadow_d[k] = zone_val(acc_q[k]);
    end
    shadow_d[ZONES_X-1] = zone_val(acc_d);
  end

  // Accumulator and shadow banks
  always_ff @(posedge iODCK) begin
    // NOTE: the banks have no reset. Each zone's first pixel overwrites its entry,
    // and the shadow bank is only read after a band end has loaded it.
    if (pix_ok) acc_q[col_q] <= acc_d;
    if (band_end) begin
      for (int k = 0; k < ZONES_X; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  // Frame FSM, pixel counters and write sequencer with registered bus outputs
  always_ff @(posedge iODCK or posedge iRST) begin
    // NOTE: sequential state uses non-blocking assignments only,
    // so every register samples values from before the edge.
    if (iRST) begin
      state_q   <= S_IDLE;
      px_q      <= '0;
      col_q     <= '0;
      line_q    <= '0;
      band_q    <= '0;
      seq_run_q <= 1'b0;
      seq_k_q   <= '0;
      wea_q     <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (iVS) begin
        // Frame start wins everywhere: restart counting and drop any pending writes
        px_q      <= '0;
        col_q     <= '0;
        line_q    <= '0;
        band_q    <= '0;
        seq_run_q <= 1'b0;
        seq_k_q   <= '0;
        wea_q     <= 1'b0;
        busy_q    <= 1'b1;
        state_q   <= S_ACTIVE;
      end else begin
        // Write sequencer: the first word comes straight from the snapshot, the rest from shadow
        wea_q <= 1'b0;
        if (band_end) begin
          wea_q     <= 1'b1;
          addr_q    <= base_d;
          data_q    <= shadow_d[0];
          seq_k_q   <= KW'(1);
          seq_run_q <= (ZONES_X > 1);
        end else if (seq_run_q) begin
          wea_q   <= 1'b1;
          addr_q  <= addr_q + 9'd1;
          data_q  <= shadow_q[seq_k_q];
          seq_k_q <= seq_k_q + KW'(1);
          if (seq_k_q == KW'(ZONES_X - 1)) seq_run_q <= 1'b0;
        end

        // Pixel position: px -> col -> line -> band carry chain
        if (pix_ok) begin
          if (px_last) begin
            px_q <= '0;
            if (col_last) begin
              col_q <= '0;
              if (line_last) begin
                line_q <= '0;
                band_q <= band_last ? '0 : band_q + BAND_W'(1);
              end else begin
                line_q <= line_q + LINE_W'(1);
              end
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end else begin
            px_q <= px_q + PX_W'(1);
          end
        end

        case (state_q)
          S_ACTIVE: if (frame_end) state_q <= S_FLUSH;
          S_FLUSH: begin
            // The last write is on the bus and no more are queued
            if (wea_q && !seq_run_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign oWEA       = wea_q;
  assign oData      = data_q;
  assign oAddress   = addr_q;
  assign oBusy      = busy_q;
  assign oFrameDone = done_q;

endmodule
